// File: rtl/apb_requester_arbiter_if.sv
// apb_requester_arbiter_if: APB bus bundle with requester and completer views
interface apb_requester_arbiter_if #(parameter int ADDR_WIDTH = 16, parameter int DATA_WIDTH = 16);
  logic pclk;
  logic preset_n;
  logic pwakeup;
  logic psel;
  logic penable;
  logic pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0] pprot;
  logic pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic pslverr;
  modport requester(output pclk, preset_n, pwakeup, psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
                    input pready, prdata, pslverr);
  modport completer(input pclk, preset_n, pwakeup, psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
                    output pready, prdata, pslverr);
endinterface

// File: rtl/apb_requester_arbiter.sv
// apb_requester_arbiter: two-requester round-robin APB arbiter replaying the winner downstream.
// Optional ACCESS watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_requester_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  apb_requester_arbiter_if.completer req0,
  apb_requester_arbiter_if.completer req1,
  apb_requester_arbiter_if.requester apb
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, next_state;
  logic last_grant, gnt, win, grant, timeout, done, real_done;
  logic pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0] pprot;
  logic unused;
  assign unused = &{1'b0, req0.penable, req1.penable, req0.pclk, req1.pclk, req0.preset_n, req1.preset_n};
`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n || state == IDLE) cnt <= '0;
    else if (state == ACCESS && !apb.pready) cnt <= cnt + 1'b1;
  assign timeout = state == ACCESS && cnt == CW'(TIMEOUT_CYCLES);
`else
  assign timeout = 1'b0;
`endif
  assign grant = req0.psel | req1.psel;
  assign win = (req0.psel & req1.psel) ? ~last_grant : req1.psel;
  assign real_done = state == ACCESS && apb.pready;
  assign done = real_done || timeout;
  always_comb begin
    next_state = state;
    next_state = (state == IDLE) ? (grant ? SETUP : IDLE) :
                 (state == SETUP) ? ACCESS : (done ? IDLE : ACCESS);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      gnt <= 1'b0;
      pwrite <= 1'b0;
      paddr <= '0;
      pwdata <= '0;
      pstrb <= '0;
      pprot <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && grant) begin
        last_grant <= win;
        gnt <= win;
        pwrite <= win ? req1.pwrite : req0.pwrite;
        paddr <= win ? req1.paddr : req0.paddr;
        pwdata <= win ? req1.pwdata : req0.pwdata;
        pstrb <= win ? req1.pstrb : req0.pstrb;
        pprot <= win ? req1.pprot : req0.pprot;
      end
    end
  end
  assign apb.pclk = clk;
  assign apb.preset_n = rst_n;
  assign apb.pwakeup = req0.pwakeup | req1.pwakeup;
  assign apb.psel = state != IDLE;
  assign apb.penable = state == ACCESS;
  assign apb.pwrite = pwrite;
  assign apb.paddr = paddr;
  assign apb.pwdata = pwdata;
  assign apb.pstrb = pstrb;
  assign apb.pprot = pprot;
  // A watchdog abort reports an error with zero data; a real completion passes through.
  assign req0.pready = done && !gnt;
  assign req0.prdata = (real_done && !gnt) ? apb.prdata : '0;
  assign req0.pslverr = done && !gnt && (real_done ? apb.pslverr : 1'b1);
  assign req1.pready = done && gnt;
  assign req1.prdata = (real_done && gnt) ? apb.prdata : '0;
  assign req1.pslverr = done && gnt && (real_done ? apb.pslverr : 1'b1);
endmodule

// File: tb/tb_apb_requester_arbiter.sv
// tb_apb_requester_arbiter: transaction-level model plus directed scenarios for the APB arbiter
module tb_apb_requester_arbiter;
  localparam int T = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  apb_requester_arbiter_if r0();
  apb_requester_arbiter_if r1();
  apb_requester_arbiter_if bus();
  apb_requester_arbiter #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst_n(rst_n), .req0(r0), .req1(r1), .apb(bus));
  logic psel_v[2], wr_v[2], wake_v[2];
  logic [15:0] addr_v[2], data_v[2];
  logic [1:0] strb_v[2];
  logic [2:0] prot_v[2];
  logic rdy[2], err[2];
  logic [15:0] rdat[2];
  assign r0.pclk = clk;
  assign r0.preset_n = rst_n;
  assign r0.penable = 1'b0;
  assign r0.psel = psel_v[0];
  assign r0.pwrite = wr_v[0];
  assign r0.pwakeup = wake_v[0];
  assign r0.paddr = addr_v[0];
  assign r0.pwdata = data_v[0];
  assign r0.pstrb = strb_v[0];
  assign r0.pprot = prot_v[0];
  assign r1.pclk = clk;
  assign r1.preset_n = rst_n;
  assign r1.penable = 1'b0;
  assign r1.psel = psel_v[1];
  assign r1.pwrite = wr_v[1];
  assign r1.pwakeup = wake_v[1];
  assign r1.paddr = addr_v[1];
  assign r1.pwdata = data_v[1];
  assign r1.pstrb = strb_v[1];
  assign r1.pprot = prot_v[1];
  assign rdy[0] = r0.pready;
  assign rdy[1] = r1.pready;
  assign rdat[0] = r0.prdata;
  assign rdat[1] = r1.prdata;
  assign err[0] = r0.pslverr;
  assign err[1] = r1.pslverr;
  // Completer: answers after wait_n ACCESS cycles unless hung.
  logic hang = 1'b0;
  int wait_n = 0;
  logic [15:0] rdata_c = '0;
  logic err_c = 1'b0;
  int acc = 0;
  assign bus.pready = bus.penable && !hang && acc >= wait_n;
  assign bus.prdata = rdata_c;
  assign bus.pslverr = err_c;
  always @(posedge clk) acc <= (bus.penable && !bus.pready) ? acc + 1 : 0;
  int checks = 0, fails = 0, cyc = 0;
  bit chk_en = 1'b0;
  int pos = -1, owner = 0, last = 1;
  logic m_wr = 1'b0;
  logic [15:0] m_addr = '0, m_data = '0;
  logic [1:0] m_strb = '0;
  logic [2:0] m_prot = '0;
  int order_q[$];
  int rcyc[2];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic bit m_real();
    return pos >= 1 && !hang && (pos - 1) >= wait_n;
  endfunction
  function automatic bit m_to();
`ifdef APB_ARB_TIMEOUT_EN
    return pos == T + 1;
`else
    return 1'b0;
`endif
  endfunction
  function automatic bit m_done();
    return m_real() || m_to();
  endfunction
  function automatic int pick();
    return (psel_v[0] && psel_v[1]) ? 1 - last : (psel_v[1] ? 1 : 0);
  endfunction
  // pos counts cycles since the grant edge: 0 = SETUP, >=1 = ACCESS, -1 = no transfer.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      pos <= -1;
      last <= 1;
      m_wr <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      m_strb <= '0;
      m_prot <= '0;
    end else if (pos < 0) begin
      if (psel_v[0] || psel_v[1]) begin
        owner <= pick();
        last <= pick();
        m_wr <= wr_v[pick()];
        m_addr <= addr_v[pick()];
        m_data <= data_v[pick()];
        m_strb <= strb_v[pick()];
        m_prot <= prot_v[pick()];
        pos <= 0;
      end
    end else if (pos == 0) pos <= 1;
    else if (m_done()) pos <= -1;
    else pos <= pos + 1;
  end
  always @(negedge clk) if (chk_en) begin
    chk("psel", bus.psel, pos >= 0);
    chk("penable", bus.penable, pos >= 1);
    chk("pwrite", bus.pwrite, m_wr);
    chk("paddr", bus.paddr, m_addr);
    chk("pwdata", bus.pwdata, m_data);
    chk("pstrb", bus.pstrb, m_strb);
    chk("pprot", bus.pprot, m_prot);
    chk("pwakeup", bus.pwakeup, wake_v[0] | wake_v[1]);
    chk("preset_n", bus.preset_n, rst_n);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("pready%0d", p), rdy[p], m_done() && owner == p);
      chk($sformatf("prdata%0d", p), rdat[p], (owner == p && m_real()) ? rdata_c : 16'h0);
      chk($sformatf("pslverr%0d", p), err[p], (owner == p && m_done()) ? (m_real() ? err_c : 1'b1) : 1'b0);
    end
  end
  task automatic xfer(input int p, input logic [15:0] a, input logic w, input logic [15:0] d,
                      input logic [1:0] s, input int n, output logic [15:0] rd, output logic er,
                      output int lat, output int pen);
    int st, k;
    @(posedge clk);
    #2;
    psel_v[p] = 1'b1;
    addr_v[p] = a;
    wr_v[p] = w;
    data_v[p] = d;
    strb_v[p] = s;
    prot_v[p] = p ? 3'd2 : 3'd5;
    st = cyc;
    pen = 0;
    rd = '0;
    er = 1'b0;
    lat = -1;
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (k < 200) begin
        @(negedge clk);
        pen += int'(bus.penable);
        if (rdy[p]) break;
        k++;
      end
      chk("xfer_bound", k >= 200, 1'b0);
      rd = rdat[p];
      er = err[p];
      lat = cyc - st;
      order_q.push_back(p);
      rcyc[p] = cyc;
      @(posedge clk);
      #2;
      addr_v[p] = a + 16'(2 * (i + 1));
      st = cyc;
      if (i == n - 1) psel_v[p] = 1'b0;
    end
  endtask
  logic [15:0] rd_a, rd_b;
  logic er_a, er_b;
  int lat_a, lat_b, pen_a, pen_b, k;
  int exp_f[5] = '{0, 1, 0, 0, 0};
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int p = 0; p < 2; p++) begin
      psel_v[p] = 1'b0; wr_v[p] = 1'b0; wake_v[p] = 1'b0;
      addr_v[p] = '0; data_v[p] = '0; strb_v[p] = '0; prot_v[p] = '0;
    end
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_psel", bus.psel, 1'b0);
    chk("rst_paddr", bus.paddr, 16'h0);
    chk("rst_pstrb", bus.pstrb, 2'b00);
    chk("rst_pready0", r0.pready, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    // single read
    rdata_c = 16'hBEEF;
    xfer(0, 16'h0010, 1'b0, 16'h0, 2'b00, 1, rd_a, er_a, lat_a, pen_a);
    chk("single_rdata", rd_a, 16'hBEEF);
    chk("single_lat", lat_a, 2);
    chk("single_err", er_a, 1'b0);
    // first tie after reset
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    order_q.delete();
    rdata_c = 16'h5555;
    fork
      xfer(0, 16'h0020, 1'b1, 16'h1234, 2'b11, 1, rd_a, er_a, lat_a, pen_a);
      xfer(1, 16'h0030, 1'b0, 16'h0, 2'b00, 1, rd_b, er_b, lat_b, pen_b);
    join
    chk("tie_first", order_q[0], 0);
    chk("tie_second", order_q[1], 1);
    chk("tie_gap", rcyc[1] - rcyc[0], 3);
    chk("tie_rdata1", rd_b, 16'h5555);
    // fairness with req0 streaming
    order_q.delete();
    wake_v[1] = 1'b1;
    fork
      xfer(0, 16'h0040, 1'b0, 16'h0, 2'b00, 4, rd_a, er_a, lat_a, pen_a);
      begin
        @(posedge clk);
        xfer(1, 16'h0080, 1'b0, 16'h0, 2'b00, 1, rd_b, er_b, lat_b, pen_b);
      end
    join
    wake_v[1] = 1'b0;
    chk("fair_n", order_q.size(), 5);
    for (int i = 0; i < 5 && i < order_q.size(); i++) chk($sformatf("fair_order%0d", i), order_q[i], exp_f[i]);
    // wait states with slave error
    wait_n = 5;
    err_c = 1'b1;
    xfer(0, 16'h0050, 1'b1, 16'hA5A5, 2'b01, 1, rd_a, er_a, lat_a, pen_a);
    chk("wait_penable_cycles", pen_a, 6);
    chk("wait_err", er_a, 1'b1);
    chk("wait_lat", lat_a, 7);
    wait_n = 0;
    err_c = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    hang = 1'b1;
    rdata_c = 16'h7777;
    fork
      begin
        xfer(1, 16'h0060, 1'b0, 16'h0, 2'b00, 1, rd_b, er_b, lat_b, pen_b);
        hang = 1'b0;
      end
      begin
        @(posedge clk);
        xfer(0, 16'h0070, 1'b0, 16'h0, 2'b00, 1, rd_a, er_a, lat_a, pen_a);
      end
    join
    chk("wd_err", er_b, 1'b1);
    chk("wd_rdata", rd_b, 16'h0);
    chk("wd_lat", lat_b, 2 + T);
    chk("wd_next_err", er_a, 1'b0);
    chk("wd_next_rdata", rd_a, 16'h7777);
`endif
    // reset during ACCESS
    hang = 1'b1;
    @(posedge clk);
    #2;
    psel_v[0] = 1'b1;
    addr_v[0] = 16'h0090;
    wr_v[0] = 1'b1;
    data_v[0] = 16'hCAFE;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (bus.penable) break;
      k++;
    end
    chk("mid_bound", k >= 50, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    psel_v[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_psel", bus.psel, 1'b0);
    chk("mid_penable", bus.penable, 1'b0);
    chk("mid_paddr", bus.paddr, 16'h0);
    chk("mid_pwdata", bus.pwdata, 16'h0);
    hang = 1'b0;
    order_q.delete();
    fork
      xfer(0, 16'h00A0, 1'b0, 16'h0, 2'b00, 1, rd_a, er_a, lat_a, pen_a);
      xfer(1, 16'h00B0, 1'b0, 16'h0, 2'b00, 1, rd_b, er_b, lat_b, pen_b);
    join
    chk("mid_tie_first", order_q[0], 0);
    chk("mid_tie_second", order_q[1], 1);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/apb_requester_arbiter.md
# apb_requester_arbiter

Two-requester, one-completer APB arbiter placed between the mainboard management requesters (QSPI management bridge on port 0, a second management path such as the Ethernet control plane on port 1) and the top-level APB bus. The block grants ownership round-robin, latches the winning request, and replays it downstream as a standard SETUP/ACCESS transfer. It routes completion status back only to the granted requester. An optional watchdog terminates transfers whose completer never asserts `pready`.

## Interface
- `TIMEOUT_CYCLES`, default 1024: ACCESS-phase cycles before the watchdog aborts; used only with `APB_ARB_TIMEOUT_EN`; minimum 2.
- `clk`  input  1  single clock; all logic is synchronous to its rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `req0`  APB.completer  DATA_WIDTH/ADDR_WIDTH of interface  requester 0 (QSPI bridge); higher priority only on the first tie after reset.
- `req1`  APB.completer  same widths  requester 1.
- `apb`  APB.requester  same widths  downstream bus. `apb.pclk`=`clk`; `apb.preset_n`=`rst_n`; `apb.pwakeup`=`req0.pwakeup | req1.pwakeup`.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- A request is `reqN.psel`=1 while in IDLE.
- **IDLE**
  - With a single requester active, grant that requester.
  - With both active, grant the requester not named by `last_grant`.
  - On grant, latch `paddr`, `pwrite`, `pwdata`, `pstrb` and `pprot` from the winner, set `last_grant`, and go to SETUP.
- **SETUP**: downstream `psel`=1, `penable`=0; go to ACCESS unconditionally.
- **ACCESS**
  - Downstream `psel`=1, `penable`=1.
  - On `apb.pready`=1, pass `pready`=1, `prdata` and `pslverr` combinationally to the granted requester, then go to IDLE.
- Non-granted requesters always see `pready`=0, `prdata`=0, `pslverr`=0. A waiting requester holds `psel` high until it is served.
- Downstream address, data, strobe and protection signals stay stable from SETUP through ACCESS completion.
- In IDLE they hold their last values; `psel`=`penable`=0.
- Upstream `penable` is ignored. A requester that keeps `psel` high after `pready` has started a new request, which is eligible in the following IDLE cycle under the round-robin rules.
- **Reset values**
  - `apb.psel`, `apb.penable`, `apb.pwrite`: 0.
  - `apb.paddr`, `apb.pwdata`, `apb.pprot`: 0.
  - `apb.pstrb`: 0.
  - All upstream `pready`/`prdata`/`pslverr`: 0.
  - `last_grant`=1, so `req0` wins the first tie.
  - State IDLE; watchdog counter 0.
- **Reset mid-transfer**: on the next edge the FSM returns to IDLE and downstream `psel` drops. No `pready` is issued for the aborted transfer, and the requester must reissue it.

## Timing
- Request sampled in IDLE at edge N.
- Downstream `psel` at N+1 (SETUP), `penable` at N+2 (ACCESS).
- Earliest upstream `pready` at N+2, i.e. 2 cycles of arbitration overhead with a zero-wait completer.
- Each completer wait state adds 1 cycle.
- Minimum 3 cycles per transfer, including the IDLE turnaround.
- Back-to-back transfers alternate between requesters when both are pending. No requester waits more than one transfer.
- Upstream `pready`/`prdata`/`pslverr` are combinational from the downstream bus while in ACCESS. There is no registered return path.

## Configuration
- Macro: `APB_ARB_TIMEOUT_EN`.
- **Defined**
  - An ACCESS-cycle counter (clog2(TIMEOUT_CYCLES+1) bits) clears on entry to SETUP and increments each ACCESS cycle without `pready`.
  - When the count reaches `TIMEOUT_CYCLES`, that cycle returns upstream `pready`=1, `pslverr`=1, `prdata`=0, and the FSM goes to IDLE, dropping downstream `psel`.
  - If `apb.pready` arrives on that same cycle, the real completion wins and `pslverr` is passed through.
- **Undefined**: no counter; ACCESS waits indefinitely; `pslverr` is always passthrough.

## Test plan
- **Single read**: `req0` reads 0x0010, completer returns 0xBEEF with 0 waits. Expect downstream `psel` at N+1, `penable` at N+2, `req0.pready`=1 with `prdata`=0xBEEF at N+2, and `req1` seeing `pready`=0 throughout.
- **First tie**: after reset, `req0` (write 0x0020←0x1234) and `req1` (read 0x0030) assert `psel` on the same cycle. Expect `req0` granted first, `req1` transfer starting 3 cycles later, and write data/strobe stable through ACCESS.
- **Fairness**: `req0` keeps `psel` asserted for 4 consecutive reads while `req1` requests once. Expect the order `req0`, `req1`, `req0`, …; `req1` is served second.
- **Wait states**: completer holds `pready` low for 5 cycles on a write with `pstrb`=2'b01. Expect `penable` held 6 cycles, `paddr`/`pwdata`/`pstrb` unchanged, and `pslverr` from the completer passed to the requester.
- **Watchdog**: `APB_ARB_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=8, completer never responds. Expect `req1.pready`=1 and `pslverr`=1 after 8 ACCESS cycles, downstream `psel` low on the next cycle, and the next pending request served normally.
- **Reset mid-transfer**: `rst_n` driven low during ACCESS for 1 cycle. Expect all downstream outputs 0 on the next edge, no upstream `pready`, and a subsequent `req0` request tie-winning as after power-on.
